// File: rtl/uart_cmd_ctrl_if.sv
// Signal bundle between the UART command controller and its environment:
// received-byte strobe in, bus write handshake out, plus halt/done/err status.
interface uart_cmd_ctrl_if;
  // rx_rcv is a one-cycle strobe qualifying rx_data (no back-pressure).
  // bus_req acts as valid and bus_ack as ready: a write transfers on any
  // cycle where both are 1, and bus_addr/bus_wdata hold steady while bus_req=1.
  logic        rx_rcv;
  logic [7:0]  rx_data;
  logic        bus_req;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic        bus_ack;
  logic        halt;
  logic        done;
  logic [2:0]  err;
  logic [2:0]  dbg_state;

  modport master (
    input  rx_rcv, rx_data, bus_ack,
    output bus_req, bus_addr, bus_wdata, halt, done, err, dbg_state
  );

  modport slave (
    output rx_rcv, rx_data, bus_ack,
    input  bus_req, bus_addr, bus_wdata, halt, done, err, dbg_state
  );
endinterface

// File: rtl/uart_cmd_ctrl.sv
// Decodes A5-framed UART commands into bus writes or a CPU halt level.
// Define CMD_CHECKSUM_EN to append and verify an XOR checksum byte.
module uart_cmd_ctrl #(
  parameter int unsigned TIMEOUT_CYC = 78125
) (
  input  logic              clk,
  input  logic              rstn,
  uart_cmd_ctrl_if.master   bus
);

  localparam logic [7:0] SYNC    = 8'hA5;
  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_HLT = 8'h02;
  localparam int         CW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GET_CMD = 3'd1,
    GET_AH  = 3'd2,
    GET_AL  = 3'd3,
    GET_DAT = 3'd4,
`ifdef CMD_CHECKSUM_EN
    GET_CHK = 3'd5,
`endif
    EXEC    = 3'd6,
    DONE    = 3'd7
  } state_t;

  state_t        r_state;
  logic [7:0]    r_cmd;
  logic [15:0]   r_addr;
  logic [7:0]    r_data;
  logic          r_bus_req;
  logic          r_halt;
  logic          r_done;
  logic [2:0]    r_err;
  logic [CW-1:0] r_tmo;

  logic w_in_get;
  logic w_tmo_hit;

`ifdef CMD_CHECKSUM_EN
  assign w_in_get = (r_state == GET_CMD) || (r_state == GET_AH) || (r_state == GET_AL) ||
                    (r_state == GET_DAT) || (r_state == GET_CHK);
`else
  assign w_in_get = (r_state == GET_CMD) || (r_state == GET_AH) || (r_state == GET_AL) ||
                    (r_state == GET_DAT);
`endif

  // A byte arriving on the expiry cycle wins over the timeout.
  assign w_tmo_hit = w_in_get && !bus.rx_rcv && (r_tmo == TMO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_cmd     <= '0;
      r_addr    <= '0;
      r_data    <= '0;
      r_bus_req <= 1'b0;
      r_halt    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= '0;
      r_tmo     <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= '0;
      if (bus.rx_rcv || !w_in_get) r_tmo <= '0;
      else                         r_tmo <= r_tmo + CW'(1);

      if (w_tmo_hit) begin
        r_err   <= 3'b001;
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: if (bus.rx_rcv && bus.rx_data == SYNC) r_state <= GET_CMD;
          GET_CMD: if (bus.rx_rcv) begin
            r_cmd   <= bus.rx_data;
            r_state <= GET_AH;
          end
          GET_AH: if (bus.rx_rcv) begin
            r_addr[15:8] <= bus.rx_data;
            r_state      <= GET_AL;
          end
          GET_AL: if (bus.rx_rcv) begin
            r_addr[7:0] <= bus.rx_data;
            r_state     <= GET_DAT;
          end
          GET_DAT: if (bus.rx_rcv) begin
            r_data <= bus.rx_data;
`ifdef CMD_CHECKSUM_EN
            r_state <= GET_CHK;
`else
            if (r_cmd == CMD_WR) begin
              r_bus_req <= 1'b1;
              r_state   <= EXEC;
            end else if (r_cmd == CMD_HLT) begin
              r_halt  <= bus.rx_data[0];
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_err   <= 3'b010;
              r_state <= IDLE;
            end
`endif
          end
`ifdef CMD_CHECKSUM_EN
          GET_CHK: if (bus.rx_rcv) begin
            if (bus.rx_data != (r_cmd ^ r_addr[15:8] ^ r_addr[7:0] ^ r_data)) begin
              r_err   <= 3'b100;
              r_state <= IDLE;
            end else if (r_cmd == CMD_WR) begin
              r_bus_req <= 1'b1;
              r_state   <= EXEC;
            end else if (r_cmd == CMD_HLT) begin
              r_halt  <= r_data[0];
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_err   <= 3'b010;
              r_state <= IDLE;
            end
          end
`endif
          // Bytes arriving in EXEC/DONE are ignored on purpose.
          EXEC: if (bus.bus_ack) begin
            r_bus_req <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= DONE;
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.bus_req   = r_bus_req;
  assign bus.bus_addr  = r_addr;
  assign bus.bus_wdata = r_data;
  assign bus.halt      = r_halt;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Self-checking bench for uart_cmd_ctrl: bus writes go through an expected
// queue; halt/done/err/timing are checked inline per scenario task.
module tb_uart_cmd_ctrl;
  localparam int TMO = 40;
  localparam logic [2:0] S_IDLE = 3'd0, S_GET_AL = 3'd3, S_DONE = 3'd7;

  logic clk;
  logic rstn;
  uart_cmd_ctrl_if bus_if ();

  uart_cmd_ctrl #(.TIMEOUT_CYC(TMO)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_if)
  );

  int n_vec = 0;
  int n_err = 0;
  logic [23:0] exp_q[$];

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // bus write scoreboard: every accepted write must match the queue head
  always @(posedge clk) begin
    if (rstn && bus_if.bus_req && bus_if.bus_ack) begin
      logic [23:0] got, want;
      got = {bus_if.bus_addr, bus_if.bus_wdata};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL bus_write_unexpected: got %06h want none", got);
      end else begin
        want = exp_q.pop_front();
        if (got !== want) begin
          n_err++;
          $display("FAIL bus_write: got %06h want %06h", got, want);
        end
      end
    end
  end

  // drivers (all enter and leave aligned to a falling edge)
  task automatic send_byte(input logic [7:0] b);
    bus_if.rx_rcv  = 1'b1;
    bus_if.rx_data = b;
    @(negedge clk);
    bus_if.rx_rcv  = 1'b0;
    bus_if.rx_data = 8'($urandom_range(0, 255));
  endtask

  task automatic send_frame(input logic [7:0] c, ah, al, d);
    send_byte(8'hA5);
    send_byte(c);
    send_byte(ah);
    send_byte(al);
    send_byte(d);
`ifdef CMD_CHECKSUM_EN
    send_byte(c ^ ah ^ al ^ d);
`endif
  endtask

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    bus_if.rx_rcv = 1'b0;
    bus_if.rx_data = 8'h00;
    bus_if.bus_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bus_req", 24'(bus_if.bus_req), 24'd0);
    chk("rst_bus_addr", 24'(bus_if.bus_addr), 24'd0);
    chk("rst_bus_wdata", 24'(bus_if.bus_wdata), 24'd0);
    chk("rst_halt", 24'(bus_if.halt), 24'd0);
    chk("rst_done", 24'(bus_if.done), 24'd0);
    chk("rst_err", 24'(bus_if.err), 24'd0);
    chk("rst_state", 24'(bus_if.dbg_state), 24'(S_IDLE));
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write_ack_held;
    bus_if.bus_ack = 1'b1;
    send_byte(8'h3C);  // noise in IDLE is discarded
    exp_q.push_back({16'h1234, 8'h56});
    send_frame(8'h01, 8'h12, 8'h34, 8'h56);
    chk("wr_req_latency", 24'(bus_if.bus_req), 24'd1);
    chk("wr_addr", 24'(bus_if.bus_addr), 24'h1234);
    chk("wr_data", 24'(bus_if.bus_wdata), 24'h56);
    @(negedge clk);
    chk("wr_req_one_cycle", 24'(bus_if.bus_req), 24'd0);
    chk("wr_done", 24'(bus_if.done), 24'd1);
    chk("wr_state_done", 24'(bus_if.dbg_state), 24'(S_DONE));
    @(negedge clk);
    chk("wr_done_pulse", 24'(bus_if.done), 24'd0);
    chk("wr_idle", 24'(bus_if.dbg_state), 24'(S_IDLE));
    bus_if.bus_ack = 1'b0;
  endtask

  task automatic test_write_ack_delayed;
    bus_if.bus_ack = 1'b0;
    exp_q.push_back({16'h0010, 8'hFF});
    send_frame(8'h01, 8'h00, 8'h10, 8'hFF);
    for (int i = 0; i < 5; i++) begin
      chk("dly_req_hold", 24'(bus_if.bus_req), 24'd1);
      chk("dly_stable", {bus_if.bus_addr, bus_if.bus_wdata}, {16'h0010, 8'hFF});
      send_byte(i == 0 ? 8'hA5 : 8'($urandom_range(0, 255)));
    end
    bus_if.bus_ack = 1'b1;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    chk("dly_req_drop", 24'(bus_if.bus_req), 24'd0);
    chk("dly_done", 24'(bus_if.done), 24'd1);
    @(negedge clk);
    chk("dly_dropped_bytes", 24'(bus_if.dbg_state), 24'(S_IDLE));
  endtask

  task automatic test_halt;
    bus_if.bus_ack = 1'b1;
    send_frame(8'h02, 8'h00, 8'h00, 8'h01);
    chk("halt_set", 24'(bus_if.halt), 24'd1);
    chk("halt_done", 24'(bus_if.done), 24'd1);
    chk("halt_no_req", 24'(bus_if.bus_req), 24'd0);
    repeat (2) @(negedge clk);
    send_frame(8'h02, 8'h00, 8'h00, 8'h00);
    chk("halt_clr", 24'(bus_if.halt), 24'd0);
    chk("halt_clr_done", 24'(bus_if.done), 24'd1);
    chk("halt_clr_no_req", 24'(bus_if.bus_req), 24'd0);
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
  endtask

  task automatic test_timeout;
    int j;
    bus_if.bus_ack = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    j = 0;
    while (j < TMO + 5 && bus_if.err === 3'b000) begin
      @(negedge clk);
      j++;
    end
    chk("tmo_err", 24'(bus_if.err), 24'b001);
    chk("tmo_cycles", 24'(j), 24'(TMO));
    chk("tmo_idle", 24'(bus_if.dbg_state), 24'(S_IDLE));
    @(negedge clk);
    chk("tmo_err_pulse", 24'(bus_if.err), 24'd0);
    bus_if.bus_ack = 1'b1;
    exp_q.push_back({16'hABCD, 8'h5A});
    send_frame(8'h01, 8'hAB, 8'hCD, 8'h5A);
    @(negedge clk);
    chk("tmo_recover_done", 24'(bus_if.done), 24'd1);
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
  endtask

  task automatic test_byte_wins;
    send_byte(8'hA5);
    send_byte(8'h01);
    repeat (TMO - 1) @(negedge clk);
    send_byte(8'h12);  // lands on the expiry edge
    chk("win_no_err", 24'(bus_if.err), 24'd0);
    chk("win_state", 24'(bus_if.dbg_state), 24'(S_GET_AL));
    bus_if.bus_ack = 1'b1;
    exp_q.push_back({16'h1234, 8'h77});
    send_byte(8'h34);
    send_byte(8'h77);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'h01 ^ 8'h12 ^ 8'h34 ^ 8'h77);
`endif
    @(negedge clk);
    chk("win_done", 24'(bus_if.done), 24'd1);
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
  endtask

  task automatic test_bad_cmd;
    bus_if.bus_ack = 1'b1;
    send_frame(8'h07, 8'h00, 8'h00, 8'h00);
    chk("bad_err", 24'(bus_if.err), 24'b010);
    chk("bad_idle", 24'(bus_if.dbg_state), 24'(S_IDLE));
    chk("bad_no_req", 24'(bus_if.bus_req), 24'd0);
    chk("bad_no_done", 24'(bus_if.done), 24'd0);
    @(negedge clk);
    chk("bad_err_pulse", 24'(bus_if.err), 24'd0);
`ifdef CMD_CHECKSUM_EN
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h00);
    chk("chk_err", 24'(bus_if.err), 24'b100);
    chk("chk_no_req", 24'(bus_if.bus_req), 24'd0);
    @(negedge clk);
`endif
    bus_if.bus_ack = 1'b0;
  endtask

  task automatic test_mid_frame_sync;
    bus_if.bus_ack = 1'b1;
    exp_q.push_back({16'hA5A5, 8'hA5});
    send_frame(8'h01, 8'hA5, 8'hA5, 8'hA5);
    chk("sync_as_data_req", 24'(bus_if.bus_req), 24'd1);
    repeat (2) @(negedge clk);
    bus_if.bus_ack = 1'b0;
  endtask

  task automatic test_reset_exec;
    bus_if.bus_ack = 1'b1;
    send_frame(8'h02, 8'h00, 8'h00, 8'h01);
    repeat (2) @(negedge clk);
    bus_if.bus_ack = 1'b0;
    send_frame(8'h01, 8'h77, 8'h88, 8'h99);
    chk("rexec_req", 24'(bus_if.bus_req), 24'd1);
    chk("rexec_halt_before", 24'(bus_if.halt), 24'd1);
    #2 rstn = 1'b0;
    #1;
    chk("rexec_req_async", 24'(bus_if.bus_req), 24'd0);
    chk("rexec_no_done", 24'(bus_if.done), 24'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("rexec_idle", 24'(bus_if.dbg_state), 24'(S_IDLE));
    chk("rexec_halt", 24'(bus_if.halt), 24'd0);
    chk("rexec_req_after", 24'(bus_if.bus_req), 24'd0);
  endtask

  initial begin
    test_reset();
    test_write_ack_held();
    test_write_ack_delayed();
    test_halt();
    test_timeout();
    test_byte_wins();
    test_bad_cmd();
    test_mid_frame_sync();
    test_reset_exec();
    repeat (3) @(negedge clk);
    chk("queue_drained", 24'(exp_q.size()), 24'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYC, default 78125, sets the inter-byte timeout in clk cycles (3 byte times at 9600 baud, 25 MHz).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 rx_rcv  input  1  one-cycle pulse from the UART receiver: byte available.
REQ-005 rx_data  input  8  received byte, valid while rx_rcv=1.
REQ-006 bus_req  output  1  write request to the system bus; held until acknowledged.
REQ-007 bus_addr  output  16  write address, stable while bus_req=1.
REQ-008 bus_wdata  output  8  write data, stable while bus_req=1.
REQ-009 bus_ack  input  1  bus accepts the write in any cycle where bus_req=1 and bus_ack=1.
REQ-010 halt  output  1  CPU halt level, set or cleared by command.
REQ-011 done  output  1  one-cycle pulse: a frame has been executed.
REQ-012 err  output  3  one-cycle error pulses: [0] timeout, [1] bad command, [2] checksum (tied 0 when the checksum feature is compiled out).

Function
REQ-013 The frame format SHALL be: SYNC=0xA5, CMD, ADDR_H, ADDR_L, DATA, then CHK when CMD_CHECKSUM_EN is defined.
REQ-014 The FSM states SHALL be IDLE, GET_CMD, GET_AH, GET_AL, GET_DAT, GET_CHK, EXEC and DONE; each GET_* state advances only on rx_rcv=1.
REQ-015 In IDLE, bytes other than 0xA5 SHALL be discarded silently; 0xA5 moves the FSM to GET_CMD.
REQ-016 CMD 0x01 (WRITE) SHALL go to EXEC, drive bus_req=1 with bus_addr={ADDR_H,ADDR_L} and bus_wdata=DATA, and hold them until bus_ack.
REQ-017 On the bus_ack cycle the FSM SHALL enter DONE, and bus_req SHALL be 0 in the following cycle; if bus_ack is already 1 on the first EXEC cycle, bus_req is high for exactly one cycle.
REQ-018 CMD 0x02 (HALT) SHALL set halt=DATA[0] on the DONE cycle; it does not touch the bus.
REQ-019 Any other CMD value SHALL pulse err[1] for one cycle after the last frame byte, skip execution and return to IDLE.
REQ-020 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-021 Latency SHALL be 1 cycle from the rx_rcv of the last frame byte to bus_req=1, or to DONE for HALT.
REQ-022 The timeout counter SHALL reload on every rx_rcv and count only in the GET_* states.
REQ-023 When the counter reaches TIMEOUT_CYC-1 without a new byte, err[0] SHALL pulse and the FSM SHALL return to IDLE; partial frame data is discarded.
REQ-024 rx_rcv arriving in EXEC or DONE SHALL be dropped, with no error; a new frame must start after return to IDLE.
REQ-025 If rx_rcv and the timeout expiry occur in the same cycle, the byte SHALL win: the byte is accepted and no timeout is flagged.
REQ-026 A 0xA5 byte received mid-frame SHALL be treated as data, not as a resync.
REQ-027 Address and data registers SHALL load only in their GET_* state; outputs never glitch in EXEC.

Reset
REQ-028 On rstn=0 the block SHALL asynchronously force: state=IDLE, bus_req=0, bus_addr=0, bus_wdata=0, halt=0, done=0, err=0, timeout counter=0.
REQ-029 Reset asserted during EXEC SHALL drop bus_req immediately, with no completion pulse.

Configuration
REQ-030 Macro CMD_CHECKSUM_EN, when defined, SHALL enable GET_CHK; CHK must equal CMD^ADDR_H^ADDR_L^DATA.
REQ-031 With CMD_CHECKSUM_EN, a CHK mismatch SHALL pulse err[2] and return to IDLE, with no execution and no err[1].
REQ-032 Without CMD_CHECKSUM_EN, GET_CHK SHALL be absent, GET_DAT SHALL go directly to execution or the error decision, and err[2] SHALL be 0.

Verification
REQ-033 Send A5 01 12 34 56 (plus CHK 71 if enabled), bus_ack held 1 -> one bus_req cycle with addr 0x1234 and data 0x56, then done pulse.
REQ-034 Send A5 01 00 10 FF, bus_ack delayed 5 cycles -> bus_req, addr 0x0010 and data 0xFF stay stable 5 cycles; bytes sent meanwhile are ignored.
REQ-035 Send A5 02 00 00 01 then A5 02 00 00 00 -> halt rises after the first frame and falls after the second; bus_req never asserts.
REQ-036 Send A5 01 12, then idle for TIMEOUT_CYC cycles -> err[0] pulse; a following full frame executes normally.
REQ-037 Send A5 07 00 00 00 -> err[1] pulse, no bus_req; with CMD_CHECKSUM_EN, A5 01 12 34 56 00 -> err[2] pulse, no bus_req.
REQ-038 Assert rstn low during EXEC -> bus_req=0 immediately; after release, state is IDLE and halt=0.
